flow_window_sequencer: RTL and testbench
========================================

Name: flow_window_sequencer

Overview:
- Controller that sequences the CE-qualified rising-edge detector on the spirometer turbine pulse line.
- Generates the detector's sample strobe and clear, and flushes stale sample history after each start.
- Counts detected edges over a fixed measurement window and hands the count to the flow-computation logic through a valid/ack handshake.

Parameters:
- CE_DIV, 50: clock cycles per detector sample strobe (50 MHz -> 1 MHz sampling); legal range >= 2.
- WINDOW_TICKS, 10000: sample strobes per measurement window; legal range >= 1.
- CNT_W, 16: edge-count width.

Ports:
- iClk  in  1  system clock
- iReset  in  1  synchronous, active-low reset
- iStart  in  1  start measurement, single-cycle pulse
- iStop  in  1  abort measurement
- iAck  in  1  consumer acknowledges oCount
- iDetPosedge  in  1  edge flag from the detector; held high between strobes
- oDetCE  out  1  detector sample strobe, one cycle wide
- oDetClr  out  1  detector synchronous clear, active-high, one cycle wide
- oBusy  out  1  high in ARM or MEASURE
- oValid  out  1  oCount valid; high until acknowledged
- oCount  out  CNT_W  edges in the last completed window
- oOverflow  out  1  last window's count saturated

Behaviour:
- Reset (iReset=0 at a clock edge): state IDLE; prescaler=0; tick counter=0; edge accumulator=0; all outputs 0.
- States:
  - IDLE -> ARM on iStart && !iStop. That transition cycle registers oDetClr=1 for one cycle and clears the prescaler, tick counter and accumulator.
  - ARM: consumes exactly 2 oDetCE strobes with counting disabled. This refills the detector's 2-bit history and suppresses the false edge a high input would produce after the clear. On the 2nd strobe -> MEASURE.
  - MEASURE: counts strobes. On the WINDOW_TICKS-th strobe -> DONE.
  - DONE: oCount <= accumulator, oValid=1, oOverflow=saturation flag (all registered on entry). Stays in DONE until iAck, then -> IDLE and oValid drops on the next cycle. oCount and oOverflow hold their value until the next DONE entry.
- Prescaler:
  - Runs only in ARM and MEASURE; held at 0 elsewhere.
  - oDetCE=1 when prescaler==CE_DIV-1; prescaler then wraps to 0.
  - The first strobe occurs CE_DIV cycles after entering ARM.
- Edge counting:
  - The accumulator increments only on cycles where state==MEASURE && oDetCE && iDetPosedge. Each input edge is therefore counted exactly once, although iDetPosedge is held for CE_DIV cycles.
  - This includes the edge flag sampled on the final window strobe.
- Saturation: the accumulator saturates at 2^CNT_W-1 and sets a sticky saturation flag. The flag is cleared on start.
- iStop in ARM or MEASURE: next state IDLE. oValid stays 0; oCount and oOverflow unchanged; oDetCE suppressed from the next cycle.
- iStop in DONE: ignored; only iAck leaves DONE.
- iStart outside IDLE: ignored.
- iStart && iStop together in IDLE: stop wins; the block stays in IDLE.
- iAck outside DONE: ignored.
- oBusy is registered from the state.
- Reset mid-operation returns the block to the reset values above, including oValid=0 and oCount=0.

Optional Feature:
- Macro: FLOW_CONTINUOUS_EN.
- Defined:
  - DONE is transient. The block loads oCount, pulses oValid for exactly one cycle and immediately re-enters MEASURE, skipping ARM and oDetClr; the accumulator restarts at 0.
  - The prescaler keeps its phase, so windows are back-to-back with no lost strobes.
  - iAck is unused. iStop still returns the block to IDLE.
- Undefined: single-shot handshake as above.

Decomposition:
- Shared package flow_pkg:
  - state encoding constants ST_IDLE, ST_ARM, ST_MEASURE, ST_DONE.
  - ARM_TICKS=2.
  - Default CE_DIV, WINDOW_TICKS and CNT_W values used across the spirometer design.
- Natural sub-module: ce_prescaler. Parameter CE_DIV; inputs iClk, iReset, iRun; output oTick; the counter clears whenever iRun=0.

Test Plan:
Bench parameters CE_DIV=4, WINDOW_TICKS=8, CNT_W=4 unless noted; the bench instantiates the detector model.
- Reset: hold iReset=0 for 3 cycles with random inputs -> all outputs 0; oDetCE stays 0 for 20 cycles after release with no iStart.
- Input held at 1 before and through iStart -> oDetClr pulses once, ARM flush, oValid rises 1 cycle after the 10th oDetCE, oCount=0.
- Input square wave of period 8 cycles (2 strobes) -> oCount=4 and oOverflow=0; oValid held until iAck, drops the cycle after iAck; oBusy=0 in IDLE.
- CNT_W=3, input period 2 strobes, WINDOW_TICKS=20 -> 10 edges, oCount=7, oOverflow=1; a following run with constant input gives oCount=0, oOverflow=0.
- Complete one run (oCount=4), then iStart, then iStop after the 5th MEASURE strobe -> IDLE next cycle, oValid=0, oCount still 4, no further oDetCE. iStart&&iStop in IDLE -> remains IDLE. iStart during MEASURE -> no effect on window length.
- FLOW_CONTINUOUS_EN defined, input period 2 strobes -> oValid 1-cycle pulses exactly 8 strobes apart, each oCount=4, no oDetClr after the first.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared types and defaults for the spirometer flow-window sequencer.
// Holds the FSM state encoding, ARM flush length and default sizing.
package flow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Strobes spent refilling the detector history after a clear.
  localparam int ARM_TICKS = 2;

  localparam int DEF_CE_DIV       = 50;
  localparam int DEF_WINDOW_TICKS = 10000;
  localparam int DEF_CNT_W        = 16;

  // Bits needed to count 0..n-1 (at least one).
  function automatic int cntW(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flow_window_sequencer_ce_prescaler.sv
// Detector sample-strobe prescaler: one-cycle oTick every CE_DIV cycles.
// Ports: iClk, iReset (sync, active-low), iRun (clears when 0), oTick.
module ce_prescaler
  import flow_pkg::*;
#(
  parameter int CE_DIV = DEF_CE_DIV
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iRun,
  output logic oTick
);

  localparam int PW = cntW(CE_DIV);
  localparam logic [PW-1:0] LAST = PW'(CE_DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      count <= '0;
    end else if (!iRun) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Gated by iRun so a stop silences the strobe on the very next cycle.
  assign oTick = iRun && (count == LAST);

endmodule

// File: rtl/flow_window_sequencer.sv
// Sequences the turbine-pulse edge detector and counts edges per window.
// Ports: iClk, iReset (sync, active-low), iStart, iStop, iAck,
//   iDetPosedge in; oDetCE, oDetClr, oBusy, oValid, oCount, oOverflow out.
// Optional: FLOW_CONTINUOUS_EN makes windows run back-to-back with a
//   one-cycle oValid pulse per window instead of the valid/ack handshake.
module flow_window_sequencer
  import flow_pkg::*;
#(
  parameter int CE_DIV       = DEF_CE_DIV,
  parameter int WINDOW_TICKS = DEF_WINDOW_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iAck,
  input  logic             iDetPosedge,
  output logic             oDetCE,
  output logic             oDetClr,
  output logic             oBusy,
  output logic             oValid,
  output logic [CNT_W-1:0] oCount,
  output logic             oOverflow
);

  localparam int TMAX =
    (WINDOW_TICKS > ARM_TICKS) ? WINDOW_TICKS : ARM_TICKS;
  localparam int TW = cntW(TMAX);
  localparam logic [TW-1:0] ARM_LAST = TW'(ARM_TICKS - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [TW-1:0]    tickCnt;
  logic [CNT_W-1:0] acc;
  logic             sat;

  logic             run;
  logic             tick;
  logic             hit;
  logic             accTop;
  logic [CNT_W-1:0] accNext;
  logic             satNext;
  logic             winEnd;

  assign run = (state == ST_ARM) || (state == ST_MEASURE);

  ce_prescaler #(
    .CE_DIV(CE_DIV)
  ) uPrescaler (
    .iClk  (iClk),
    .iReset(iReset),
    .iRun  (run),
    .oTick (tick)
  );

  assign oDetCE = tick;

  // The detector flag is held between strobes, so only the strobe
  // cycle may count it; otherwise one edge would count CE_DIV times.
  assign hit     = (state == ST_MEASURE) && tick && iDetPosedge;
  assign accTop  = (acc == CNT_MAX);
  assign accNext = (hit && !accTop) ? acc + 1'b1 : acc;
  assign satNext = sat || (hit && accTop);
  assign winEnd  = tick && (tickCnt == WIN_LAST);

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state     <= ST_IDLE;
      tickCnt   <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      oDetClr   <= 1'b0;
      oBusy     <= 1'b0;
      oValid    <= 1'b0;
      oCount    <= '0;
      oOverflow <= 1'b0;
    end else begin
      oDetClr <= 1'b0;
`ifdef FLOW_CONTINUOUS_EN
      oValid  <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (iStart && !iStop) begin
            state   <= ST_ARM;
            oDetClr <= 1'b1;
            oBusy   <= 1'b1;
            tickCnt <= '0;
            acc     <= '0;
            sat     <= 1'b0;
          end
        end
        ST_ARM: begin
          if (iStop) begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end else if (tick) begin
            if (tickCnt == ARM_LAST) begin
              state   <= ST_MEASURE;
              tickCnt <= '0;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end
        ST_MEASURE: begin
          if (iStop) begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end else begin
            acc <= accNext;
            sat <= satNext;
            if (winEnd) begin
              // Include the edge seen on the closing strobe.
              oCount    <= accNext;
              oOverflow <= satNext;
              oValid    <= 1'b1;
              tickCnt   <= '0;
`ifdef FLOW_CONTINUOUS_EN
              // Stay in MEASURE: prescaler phase and detector
              // history carry straight into the next window.
              acc       <= '0;
              sat       <= 1'b0;
`else
              state     <= ST_DONE;
              oBusy     <= 1'b0;
`endif
            end else if (tick) begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (iAck) begin
            state  <= ST_IDLE;
            oValid <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_window_sequencer.sv
// Scoreboard bench for flow_window_sequencer with a detector model.
// Two instances: a main one and a narrow-counter one for saturation.
module tb_flow_window_sequencer;

  localparam int CE  = 4;
  localparam int WA  = 8;
  localparam int CWA = 4;
  localparam int WB  = 20;
  localparam int CWB = 3;
  localparam int MEM = 16384;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic iReset = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ack = 1'b0;
  logic pin = 1'b0;

  logic [1:0] histA = 2'b00;
  logic [1:0] histB = 2'b00;
  logic detA, detB;

  logic ceA, clrA, busyA, validA, ovfA;
  logic [CWA-1:0] cntA;
  logic ceB, clrB, busyB, validB, ovfB;
  logic [CWB-1:0] cntB;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int clrSeen = 0;
  int startsAcc = 0;
  int lastA = 0;
  int lastB = 0;
  bit lastOvfA = 0;
  bit lastOvfB = 0;

  bit   pinMem [MEM];
  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;
  logic pvA = 1'b0;
  logic pvB = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CE-qualified rising-edge detector: 2-bit history, [0] newest.
  always @(posedge clk) begin
    if (clrA) histA <= 2'b00;
    else if (ceA) histA <= {histA[0], pin};
    if (clrB) histB <= 2'b00;
    else if (ceB) histB <= {histB[0], pin};
  end
  assign detA = (histA == 2'b01);
  assign detB = (histB == 2'b01);

  flow_window_sequencer #(
    .CE_DIV(CE), .WINDOW_TICKS(WA), .CNT_W(CWA)
  ) dutA (
    .iClk(clk), .iReset(iReset), .iStart(start), .iStop(stop),
    .iAck(ack), .iDetPosedge(detA), .oDetCE(ceA), .oDetClr(clrA),
    .oBusy(busyA), .oValid(validA), .oCount(cntA), .oOverflow(ovfA)
  );

  flow_window_sequencer #(
    .CE_DIV(CE), .WINDOW_TICKS(WB), .CNT_W(CWB)
  ) dutB (
    .iClk(clk), .iReset(iReset), .iStart(start), .iStop(stop),
    .iAck(ack), .iDetPosedge(detB), .oDetCE(ceB), .oDetClr(clrB),
    .oBusy(busyB), .oValid(validB), .oCount(cntB), .oOverflow(ovfB)
  );

  task automatic check(input string name, input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Window m of a run started in cycle s: strobe j samples the pin in
  // cycle s+j*CE; strobes 1,2 flush; an edge is a 0 then 1 sample pair.
  function automatic exp_t model(input int s, input int m,
                                 input int w, input int cw);
    exp_t e;
    int edges;
    int mx;
    edges = 0;
    mx = (1 << cw) - 1;
    for (int j = 2 + m * w; j <= 1 + (m + 1) * w; j++)
      if (pinMem[s + j * CE] && !pinMem[s + (j - 1) * CE]) edges++;
    e.cyc = s + (2 + (m + 1) * w) * CE + 1;
    e.cnt = (edges > mx) ? mx : edges;
    e.ovf = (edges > mx);
    return e;
  endfunction

  // Monitor: pop an expectation on each rising oValid.
  always @(negedge clk) begin
    if (clrA) clrSeen <= clrSeen + 1;
    pvA <= validA;
    pvB <= validB;
    if (validA && !pvA) begin
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL A_unexpected_valid: at cycle %0d none expected",
                 cyc);
      end else begin
        eA = qA.pop_front();
        check("A_valid_cycle", cyc, eA.cyc);
        check("A_count", cntA, eA.cnt);
        check("A_overflow", ovfA, eA.ovf);
      end
    end
    if (validB && !pvB) begin
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL B_unexpected_valid: at cycle %0d none expected",
                 cyc);
      end else begin
        eB = qB.pop_front();
        check("B_valid_cycle", cyc, eB.cyc);
        check("B_count", cntB, eB.cnt);
        check("B_overflow", ovfB, eB.ovf);
      end
    end
`ifdef FLOW_CONTINUOUS_EN
    if (pvA) check("A_pulse_width", validA, 0);
    if (pvB) check("B_pulse_width", validB, 0);
`endif
  end

  task automatic step();
    @(negedge clk);
    pin = pinMem[cyc];
  endtask

  // mode: 0 random, 1 const high, 2 square period 2 strobes, 3 const low
  task automatic fillPin(input int mode);
    int base;
    base = cyc;
    for (int c = base + 1; c < base + 400; c++) begin
      unique case (mode)
        0: pinMem[c] = bit'($urandom_range(1, 0));
        1: pinMem[c] = 1'b1;
        2: pinMem[c] = bit'(((c - base) / CE) % 2);
        default: pinMem[c] = 1'b0;
      endcase
    end
  endtask

  task automatic doRun(input int mode, input int stopOff,
                       input bit midStart);
    int s;
    int n;
    int viol;
    exp_t e;
    fillPin(mode);
    repeat ($urandom_range(6, 2)) step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    startsAcc++;
    check("clr_pulse_A", clrA, 1);
    check("clr_pulse_B", clrB, 1);
    check("busy_arm", busyA && busyB, 1);
    if (stopOff > 0) begin
      while (cyc < s + stopOff) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_busyA", busyA, 0);
      check("stop_busyB", busyB, 0);
      check("stop_valid", validA || validB, 0);
      check("stop_cntA", cntA, lastA);
      check("stop_ovfA", ovfA, lastOvfA);
      check("stop_cntB", cntB, lastB);
      check("stop_ovfB", ovfB, lastOvfB);
      viol = 0;
      repeat (20) begin
        step();
        if (ceA || ceB) viol++;
      end
      check("stop_no_ce", viol, 0);
      return;
    end
    e = model(s, 0, WA, CWA);
    qA.push_back(e);
    lastA = e.cnt;
    lastOvfA = e.ovf;
    e = model(s, 0, WB, CWB);
    qB.push_back(e);
    lastB = e.cnt;
    lastOvfB = e.ovf;
    n = 0;
    while (!(validA && validB) && n < 400) begin
      step();
      n++;
      start = midStart && (cyc == s + 4 * CE + 2);
    end
    start = 1'b0;
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: validA=%0b validB=%0b want 1 1",
               validA, validB);
      qA.delete();
      qB.delete();
      return;
    end
    repeat ($urandom_range(4, 0)) step();
    check("valid_holdA", validA, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_in_done", validA && validB, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_dropA", validA, 0);
    check("ack_dropB", validB, 0);
    check("idle_busy", busyA || busyB, 0);
    check("hold_cntA", cntA, lastA);
    check("hold_cntB", cntB, lastB);
  endtask

  initial begin
    int viol;
    int s;
    int t;
    exp_t e;
    for (int i = 0; i < MEM; i++) pinMem[i] = bit'($urandom_range(1, 0));

    iReset = 1'b0;
    repeat (3) begin
      step();
      start = $urandom_range(1, 0);
      stop = $urandom_range(1, 0);
      ack = $urandom_range(1, 0);
    end
    step();
    check("rst_ce", ceA || ceB, 0);
    check("rst_clr", clrA || clrB, 0);
    check("rst_busy", busyA || busyB, 0);
    check("rst_valid", validA || validB, 0);
    check("rst_cntA", cntA, 0);
    check("rst_cntB", cntB, 0);
    check("rst_ovf", ovfA || ovfB, 0);
    iReset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    ack = 1'b0;
    viol = 0;
    repeat (20) begin
      step();
      if (ceA || ceB || busyA || clrA) viol++;
    end
    check("idle_no_ce", viol, 0);

`ifdef FLOW_CONTINUOUS_EN
    fillPin(2);
    repeat (3) step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    startsAcc++;
    t = s + 170;
    for (int m = 0; s + (2 + (m + 1) * WA) * CE < t; m++) begin
      e = model(s, m, WA, CWA);
      check("cont_model_A", e.cnt, 4);
      qA.push_back(e);
    end
    for (int m = 0; s + (2 + (m + 1) * WB) * CE < t; m++)
      qB.push_back(model(s, m, WB, CWB));
    while (cyc < t) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cont_stop_busy", busyA || busyB, 0);
`else
    doRun(1, 0, 1'b0);
    doRun(2, 0, 1'b0);
    doRun(2, 7 * CE + 1, 1'b0);
    step();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", busyA || busyB, 0);
    check("startstop_clr", clrA || clrB, 0);
    doRun(2, 0, 1'b1);
    doRun(3, 0, 1'b0);
    for (int r = 0; r < 18; r++) begin
      if ($urandom_range(3, 0) == 0)
        doRun($urandom_range(3, 0), $urandom_range(10 * CE, 1), 1'b0);
      else
        doRun($urandom_range(3, 0), 0, bit'($urandom_range(1, 0)));
    end
    doRun(2, 0, 1'b0);
    fillPin(0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    startsAcc++;
    repeat (30) step();
    iReset = 1'b0;
    step();
    iReset = 1'b1;
    check("midrst_valid", validA || validB, 0);
    check("midrst_cntA", cntA, 0);
    check("midrst_cntB", cntB, 0);
    check("midrst_ovfB", ovfB, 0);
    check("midrst_busy", busyA || busyB, 0);
`endif
    repeat (30) step();
    check("clr_total", clrSeen, startsAcc);
    check("pendingA", qA.size(), 0);
    check("pendingB", qB.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
